// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with valid/ready load, selectable bit order
// and an external bit-rate enable; back-to-back frames reload on the last bit.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] FILL = {WIDTH{IDLE_LEVEL}};

  piso_state_t      state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt, shreg_adv;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             on_last, accept;

  assign on_last    = (state == SHIFT) && (cnt == LAST);
  assign load_ready = (state == IDLE) || (on_last && shift_en);
  assign accept     = load_valid && load_ready;

  // Shift toward the output end; vacated bits take the idle level.
  assign shreg_adv = MSB_FIRST ? {shreg[WIDTH-2:0], IDLE_LEVEL}
                               : {IDLE_LEVEL, shreg[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= FILL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          shreg_nxt = load_data;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (cnt != LAST) begin
            shreg_nxt = shreg_adv;
            cnt_nxt   = cnt + 1'b1;
          end else if (accept) begin
            shreg_nxt = load_data;
            cnt_nxt   = '0;
          end else begin
            state_nxt = IDLE;
            shreg_nxt = FILL;
            cnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        shreg_nxt = FILL;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs come straight from registers so shift_en cannot glitch sout.
  always_comb begin
    sout       = IDLE_LEVEL;
    sout_valid = 1'b0;
    sout_first = 1'b0;
    sout_last  = 1'b0;
    if (state == SHIFT) begin
      sout       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
      sout_valid = 1'b1;
      sout_first = (cnt == '0);
      sout_last  = (cnt == LAST);
    end
  end

  assign busy = sout_valid;

endmodule

// File: tb/tb_piso_serializer.sv
// Checks MSB-first and LSB-first instances against a word/bit-index model.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] load_data = '0;
  logic         load_valid = 1'b0;
  logic         shift_en = 1'b0;

  logic m_ready, m_sout, m_vld, m_first, m_last, m_busy;
  logic l_ready, l_sout, l_vld, l_first, l_last, l_busy;

  int checks = 0;
  int failures = 0;

  // Reference model: the active word and the index of the bit on the line.
  logic         md_act = 1'b0;
  logic [W-1:0] md_word = '0;
  int           md_k = 0;

  logic [31:0] cap_m = '0;
  logic [31:0] cap_l = '0;
  int          busy_cyc = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(m_ready), .shift_en(shift_en), .sout(m_sout),
    .sout_valid(m_vld), .sout_first(m_first), .sout_last(m_last), .busy(m_busy)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(l_ready), .shift_en(shift_en), .sout(l_sout),
    .sout_valid(l_vld), .sout_first(l_first), .sout_last(l_last), .busy(l_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ready();
    return !md_act || (md_k == W - 1 && shift_en);
  endfunction

  task automatic check_outputs();
    logic em, el;
    em = md_act ? md_word[W-1-md_k] : 1'b0;
    el = md_act ? md_word[md_k] : 1'b0;
    chk("m_sout", m_sout, em);
    chk("l_sout", l_sout, el);
    chk("m_valid", m_vld, md_act);
    chk("l_valid", l_vld, md_act);
    chk("m_first", m_first, md_act && md_k == 0);
    chk("l_first", l_first, md_act && md_k == 0);
    chk("m_last", m_last, md_act && md_k == W - 1);
    chk("l_last", l_last, md_act && md_k == W - 1);
    chk("m_busy", m_busy, md_act);
    chk("l_busy", l_busy, md_act);
    chk("m_ready", m_ready, exp_ready());
    chk("l_ready", l_ready, exp_ready());
  endtask

  task automatic model_update();
    logic acc;
    acc = load_valid && exp_ready();
    if (!md_act) begin
      if (acc) begin md_act = 1'b1; md_word = load_data; md_k = 0; end
    end else if (shift_en) begin
      if (md_k != W - 1) md_k++;
      else if (acc) begin md_word = load_data; md_k = 0; end
      else md_act = 1'b0;
    end
  endtask

  // One clock: drive inputs, compare at the falling edge, advance the model.
  task automatic step(input logic v, input logic [W-1:0] d, input logic se);
    load_valid = v;
    load_data  = d;
    shift_en   = se;
    @(negedge clk);
    check_outputs();
    if (m_busy) busy_cyc++;
    if (m_vld && shift_en) begin
      cap_m = {cap_m[30:0], m_sout};
      cap_l = {l_sout, cap_l[31:1]};
    end
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cap();
    cap_m = '0;
    cap_l = '0;
    busy_cyc = 0;
  endtask

  initial begin
    logic held;
    // Reset state, with rst still asserted.
    #2;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // A5 at full rate, both bit orders.
    clr_cap();
    step(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < W + 2; i++) step(1'b0, 8'h00, 1'b1);
    chk("a5_msb_stream", cap_m[7:0], 32'hA5);
    chk("a5_lsb_stream", cap_l[31:24], 32'hA5);

    // Back-to-back F0 then 0F with load_valid held.
    clr_cap();
    step(1'b1, 8'hF0, 1'b1);
    for (int i = 0; i < W - 1; i++) step(1'b1, 8'hF0, 1'b1);
    step(1'b1, 8'h0F, 1'b1);
    for (int i = 0; i < W + 2; i++) step(1'b0, 8'h00, 1'b1);
    chk("b2b_stream", cap_m[15:0], 32'hF00F);
    chk("b2b_busy", busy_cyc, 32'd16);

    // shift_en every third cycle: each bit held three cycles.
    clr_cap();
    for (int i = 0; i < 28; i++) step(i == 0, 8'h81, (i % 3) == 0);
    chk("slow_stream", cap_m[7:0], 32'h81);
    chk("slow_busy", busy_cyc, 32'd24);

    // FF offered at bit 3 of a 5A frame; held until taken on the last bit.
    clr_cap();
    step(1'b1, 8'h5A, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < W + 2; i++) step(1'b0, 8'h00, 1'b1);
    chk("late_load_stream", cap_m[15:0], 32'h5AFF);

    // Async reset at bit 4, between edges.
    step(1'b1, 8'hC3, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    md_act = 1'b0;
    md_k = 0;
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    clr_cap();
    step(1'b1, 8'h3C, 1'b1);
    chk("post_rst_first", m_first, 1'b1);
    for (int i = 0; i < W + 1; i++) step(1'b0, 8'h00, 1'b1);
    chk("post_rst_stream", cap_m[7:0], 32'h3C);
    chk("post_rst_lsb", cap_l[31:24], 32'h3C);

    // Random traffic; a word once offered is held until accepted.
    held = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic v;
      logic [W-1:0] d;
      if (held) begin
        v = 1'b1;
        d = load_data;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        d = W'($urandom);
      end
      step(v, d, $urandom_range(0, 2) != 0);
      held = v && !(load_valid && m_ready) && md_act;
      if (held && !md_act) held = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out shift register with a valid/ready load handshake, selectable bit order and an external shift-enable (bit-rate tick).
- Accepts one WIDTH-bit word, emits it one bit per enabled cycle, and flags the first and last bit of each frame.
- Supports back-to-back frames with no idle gap.
- Sits between a parallel datapath (register file, FIFO read side) and a serial line driver.

Parameters:
- WIDTH, 8, word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_LEVEL, 0, value driven on sout when no frame is active; also the fill value shifted into vacated bits.

Ports:
- clk  in  1  clock, rising edge active.
- rst  in  1  reset, asynchronous, active-high.
- load_data  in  WIDTH  parallel word to serialise.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  block can accept a word this cycle.
- shift_en  in  1  advance one bit this cycle (bit-rate tick; tie high for full rate).
- sout  out  1  serial data.
- sout_valid  out  1  sout carries a frame bit.
- sout_first  out  1  current bit is bit 0 of the frame.
- sout_last  out  1  current bit is bit WIDTH-1 of the frame.
- busy  out  1  a frame is in progress (equal to sout_valid).

Behaviour:
- State is held in a register; states are IDLE and SHIFT.
- Reset (async assert; registers released at the next clk edge after deassert):
  - state = IDLE, shreg = all IDLE_LEVEL, bit count = 0.
  - Outputs during reset: sout = IDLE_LEVEL, sout_valid = sout_first = sout_last = busy = 0, load_ready = 1 (load_ready is combinational from state).
- Accept = load_valid & load_ready.
- load_ready = (state == IDLE) | (state == SHIFT & cnt == WIDTH-1 & shift_en).
- IDLE:
  - On accept: shreg <= load_data, cnt <= 0, state -> SHIFT.
  - Otherwise hold.
- SHIFT:
  - sout = shreg[WIDTH-1] if MSB_FIRST, else shreg[0]. This is combinational from registers, so there is no glitch from shift_en.
  - sout_valid = 1, sout_first = (cnt == 0), sout_last = (cnt == WIDTH-1).
  - shift_en = 0: hold shreg and cnt; the bit stays on sout indefinitely.
  - shift_en = 1 and cnt < WIDTH-1: shift toward the output end, fill with IDLE_LEVEL, cnt <= cnt + 1.
  - shift_en = 1 and cnt == WIDTH-1:
    - If accept: reload shreg <= load_data, cnt <= 0, stay in SHIFT. There is no gap cycle, and the next cycle shows sout_first = 1.
    - Else: state -> IDLE, shreg <= all IDLE_LEVEL.
- Latency: the first bit appears on sout the cycle after accept. A frame occupies WIDTH shift_en pulses.
- load_data is sampled only on accept. Changes while busy are ignored.
- load_valid while busy and not on the last bit: load_ready = 0. The word is not taken, and the upstream must hold it.
- Counter width = $clog2(WIDTH). cnt never exceeds WIDTH-1, and wrap is not allowed.
- Async reset mid-frame: the frame is aborted immediately. Outputs go to their reset values, and no partial frame resumes after release.
- shift_en in IDLE has no effect.

Decomposition:
- Shared package piso_pkg:
  - typedef enum of the serializer states {IDLE, SHIFT}.
  - Function cnt_width(WIDTH) returning $clog2(WIDTH).
- No sub-module: single module of roughly 120-160 lines. The counter and the shifter are kept inline because they share the same enable.

Test Plan:
- WIDTH=8, MSB_FIRST=1, shift_en=1, load 8'hA5 -> sout over 8 cycles = 1,0,1,0,0,1,0,1; sout_first on cycle 1, sout_last on cycle 8; then sout_valid=0, sout=0.
- MSB_FIRST=0, load 8'hA5 -> sout = 1,0,1,0,0,1,0,1 reversed order (LSB first: 1,0,1,0,0,1,0,1 read from bit 0 up), checked bit-by-bit against 8'hA5.
- Back-to-back: load_valid held with 8'hF0 then 8'h0F -> 16 contiguous valid bits 11110000_00001111; load_ready high only on idle and on the last bit; no gap cycle.
- shift_en pulsed every 3rd cycle, load 8'h81 -> each bit held exactly 3 cycles; busy for 24 cycles; load_ready=0 throughout except the final-bit enable cycle.
- load_valid asserted on bit 3 of a frame with 8'hFF -> not accepted until the last-bit cycle; the current frame bits are unchanged.
- rst asserted mid-frame at bit 4 (async, between edges) -> sout_valid=0, sout=IDLE_LEVEL, load_ready=1 immediately; after release, a new load 8'h3C serialises correctly from sout_first.
